// File: rtl/write_fifo_ctrl_dpath.sv
// Write-side pointer and flag datapath for an asynchronous FIFO.
// Tracks the binary write pointer and derives the full flag and memory write
// strobe combinationally from the synchronized read pointer. One slot is kept
// empty to tell full from empty, so usable capacity is 2**ADDR_WIDTH-1.
// Optional build macro: WRITE_FIFO_ALMOST_FULL_EN adds w_almost_full_out.
module write_fifo_ctrl_dpath #(
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  w_clk_in,
    input  logic                  w_reset_in,
    input  logic                  w_request_in,
    input  logic [ADDR_WIDTH-1:0] r_ptr_in,
    output logic                  w_full_out,
    output logic                  w_enable_out,
    output logic [ADDR_WIDTH-1:0] w_addr_out,
    output logic [ADDR_WIDTH-1:0] w_ptr_next_out
`ifdef WRITE_FIFO_ALMOST_FULL_EN
    ,
    output logic                  w_almost_full_out
`endif
);

    logic [ADDR_WIDTH-1:0] w_ptr_q;
    logic [ADDR_WIDTH-1:0] w_ptr_d;
    logic [ADDR_WIDTH-1:0] w_ptr_inc;
    logic                  w_full;
    logic                  w_enable;

    // Flags and next pointer; r_ptr_in feeds the full flag with no register so
    // a read seen this cycle frees a slot for a write in the same cycle.
    always_comb begin
        w_ptr_inc = w_ptr_q + ADDR_WIDTH'(1);
        w_full    = (w_ptr_inc == r_ptr_in);
        w_enable  = w_request_in & ~w_full;
        w_ptr_d   = w_ptr_q;
        if (w_enable) begin
            w_ptr_d = w_ptr_inc;
        end
    end

    // Write pointer register; reset dominates a simultaneous write.
    always_ff @(posedge w_clk_in) begin
        if (w_reset_in) begin
            w_ptr_q <= '0;
        end else begin
            w_ptr_q <= w_ptr_d;
        end
    end

    assign w_addr_out     = w_ptr_q;
    assign w_ptr_next_out = w_ptr_inc;
    assign w_full_out     = w_full;
    assign w_enable_out   = w_enable;

`ifdef WRITE_FIFO_ALMOST_FULL_EN
    logic [ADDR_WIDTH-1:0] w_ptr_inc2;

    // Almost full: one free slot left, or already full.
    always_comb begin
        w_ptr_inc2        = w_ptr_q + ADDR_WIDTH'(2);
        w_almost_full_out = (w_ptr_inc2 == r_ptr_in) | w_full;
    end
`endif

endmodule

// File: tb/tb_write_fifo_ctrl_dpath.sv
// Testbench for write_fifo_ctrl_dpath: directed scenarios followed by random
// traffic, checked against an occupancy-based model of the write side.
module tb_write_fifo_ctrl_dpath;

    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst;
    logic          req;
    logic [AW-1:0] rptr;
    logic          full;
    logic          en;
    logic [AW-1:0] addr;
    logic [AW-1:0] nxt;
`ifdef WRITE_FIFO_ALMOST_FULL_EN
    logic          afull;
`endif

    int checks = 0;
    int errors = 0;

    int m_wp    = 0;
    bit m_valid = 0;

    write_fifo_ctrl_dpath #(.ADDR_WIDTH(AW)) dut (
        .w_clk_in       (clk),
        .w_reset_in     (rst),
        .w_request_in   (req),
        .r_ptr_in       (rptr),
        .w_full_out     (full),
        .w_enable_out   (en),
        .w_addr_out     (addr),
        .w_ptr_next_out (nxt)
`ifdef WRITE_FIFO_ALMOST_FULL_EN
        ,
        .w_almost_full_out (afull)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive at negedge, check combinational outputs, then
    // advance the model at the rising edge.
    task automatic cycle(input bit r, input bit q, input int rp);
        int  occ;
        bit  m_full;
        bit  m_en;
        @(negedge clk);
        rst  = r;
        req  = q;
        rptr = AW'(rp % DEPTH);
        #1;
        occ    = (m_wp - (rp % DEPTH) + DEPTH) % DEPTH;
        m_full = (occ == DEPTH - 1);
        m_en   = q && !m_full;
        if (m_valid) begin
            chk("addr",   32'(addr), 32'(m_wp));
            chk("next",   32'(nxt),  32'((m_wp + 1) % DEPTH));
            chk("full",   32'(full), 32'(m_full));
            chk("enable", 32'(en),   32'(m_en));
`ifdef WRITE_FIFO_ALMOST_FULL_EN
            chk("afull",  32'(afull), 32'(occ >= DEPTH - 2));
`endif
        end
        @(posedge clk);
        if (r) begin
            m_wp    = 0;
            m_valid = 1;
        end else if (m_valid && m_en) begin
            m_wp = (m_wp + 1) % DEPTH;
        end
    endtask

    initial begin
        rst  = 1'b1;
        req  = 1'b0;
        rptr = '0;

        // Reset for three cycles with no request.
        repeat (3) cycle(1, 0, 0);
        cycle(0, 0, 0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_en",   32'(en),   32'd0);

        // Fill: seven writes step the pointer 1..7.
        for (int i = 0; i < 7; i++) cycle(0, 1, 0);
        // Held request while full must be dropped.
        for (int i = 0; i < 3; i++) cycle(0, 1, 0);
        chk("full_addr", 32'(addr), 32'd7);
        chk("full_flag", 32'(full), 32'd1);
        chk("full_en",   32'(en),   32'd0);

        // Read pointer sweep with no request; full clears and returns.
        for (int i = 0; i <= 8; i++) cycle(0, 0, i);
        chk("sweep_addr", 32'(addr), 32'd7);

        // Wrap 7 -> 0 -> 1 -> 2, then full at 2 with read pointer 3.
        for (int i = 0; i < 5; i++) cycle(0, 1, 3);
        chk("wrap_addr", 32'(addr), 32'd2);
        chk("wrap_full", 32'(full), 32'd1);

        // Reset while full with request held.
        cycle(1, 1, 3);
        cycle(0, 0, 0);
        chk("midrst_addr", 32'(addr), 32'd0);
        chk("midrst_full", 32'(full), 32'd0);
        chk("midrst_next", 32'(nxt),  32'd1);

        // Random traffic, including occasional resets.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 40) == 0), $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, DEPTH - 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/write_fifo_ctrl_dpath.md
WRITE_FIFO_CTRL_DPATH -- requirements
Module: write_fifo_ctrl_dpath

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 3, meaning pointer/address width; FIFO depth is 2**ADDR_WIDTH slots.
REQ-002 SHALL have port w_clk_in, input, 1, write-domain clock.
REQ-003 SHALL have port w_reset_in, input, 1, reset; one clock (w_clk_in); reset is synchronous and active-high.
REQ-004 SHALL have port w_request_in, input, 1, write request from producer.
REQ-005 SHALL have port r_ptr_in, input, ADDR_WIDTH, binary read pointer, already synchronized into the write domain.
REQ-006 SHALL have port w_full_out, output, 1, FIFO full flag.
REQ-007 SHALL have port w_enable_out, output, 1, memory write strobe for the current cycle.
REQ-008 SHALL have port w_addr_out, output, ADDR_WIDTH, present binary write pointer (memory write address).
REQ-009 SHALL have port w_ptr_next_out, output, ADDR_WIDTH, present pointer + 1 modulo 2**ADDR_WIDTH.

Function
REQ-010 Write pointer SHALL be an ADDR_WIDTH-bit binary register; w_addr_out SHALL equal it directly.
REQ-011 w_ptr_next_out SHALL be combinational (w_addr_out + 1) truncated to ADDR_WIDTH bits (2**ADDR_WIDTH-1 wraps to 0).
REQ-012 w_full_out SHALL be combinational: 1 when w_ptr_next_out == r_ptr_in, else 0; usable capacity is 2**ADDR_WIDTH-1 entries.
REQ-013 w_enable_out SHALL be combinational: w_request_in AND NOT w_full_out.
REQ-014 On a rising w_clk_in edge with w_enable_out=1, the pointer SHALL load w_ptr_next_out; otherwise it SHALL hold.
REQ-015 Request while full SHALL be dropped: no pointer change, w_enable_out=0, no other side effect.
REQ-016 Write latency: address presented in cycle N; w_addr_out advances at the N+1 clock edge.
REQ-017 A change of r_ptr_in SHALL update w_full_out in the same cycle (no extra register); a write in the cycle full deasserts SHALL be accepted.
REQ-018 The pointer SHALL wrap from 2**ADDR_WIDTH-1 to 0 without any flag or stall.
REQ-019 w_request_in held low SHALL leave all state unchanged for any number of cycles.

Reset
REQ-020 While w_reset_in=1 at a clock edge, the pointer SHALL become 0 regardless of w_request_in; reset dominates a simultaneous write.
REQ-021 After reset with r_ptr_in=0: w_addr_out=0, w_ptr_next_out=1, w_full_out=0, w_enable_out=w_request_in.
REQ-022 Reset asserted mid-operation (including while full) SHALL return to the REQ-021 state at the next edge.

Configuration
REQ-023 Macro WRITE_FIFO_ALMOST_FULL_EN: when defined, SHALL add output w_almost_full_out (1 bit), combinational 1 when (w_addr_out + 2) mod 2**ADDR_WIDTH == r_ptr_in, or when w_full_out=1; when undefined the port and logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-024 Reset 3 cycles, r_ptr_in=0, request=0 -> w_addr_out=0, w_full_out=0, w_enable_out=0.
REQ-025 r_ptr_in=0, request=1 for 7 cycles -> w_addr_out steps 1..7; after 7th edge w_full_out=1, w_enable_out=0.
REQ-026 Full, request=1 for 3 cycles -> w_addr_out stays 7, w_full_out stays 1, w_enable_out=0.
REQ-027 Full at 7, request=0, r_ptr_in stepped 0..8 (truncated) -> w_full_out=0 as soon as r_ptr_in=1, returns to 1 when r_ptr_in=0 again; w_addr_out stays 7.
REQ-028 r_ptr_in=3, pointer at 7, request=1 -> writes to 7, wraps to 0, then 1; full at pointer 2 (next=3).
REQ-029 Assert w_reset_in while full with request=1 -> next edge w_addr_out=0, w_full_out=0; with WRITE_FIFO_ALMOST_FULL_EN, w_almost_full_out=1 at pointer 6 when r_ptr_in=0.
